// File: rtl/roalogic_dbg_pkg.sv
// ---------------------------------------------------------------------------
// roalogic_dbg_pkg
// Shared definitions for the debug data-register bridge:
//   - dbg_cmd_e   : 2-bit command field at the LSBs of a shifted frame
//   - dbg_state_e : bus-transfer FSM states
//   - STAT_*      : bit positions of the status word returned on DR capture
// No ports (package).
// ---------------------------------------------------------------------------
package roalogic_dbg_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_WRITE  = 2'b01,
    CMD_READ   = 2'b10,
    CMD_STATUS = 2'b11
  } dbg_cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } dbg_state_e;

  // Status bits in the low part of the captured DR word
  localparam int unsigned STAT_BUSY_BIT    = 0;
  localparam int unsigned STAT_OVERRUN_BIT = 1;
  localparam int unsigned STAT_BUS_ERR_BIT = 2;
  localparam int unsigned STAT_W           = 3;

endpackage

// File: rtl/roalogic_dbg_dr_shifter.sv
// ---------------------------------------------------------------------------
// roalogic_dbg_dr_shifter
// DR_W-bit debug data register. Parallel-loads on capture, shifts towards
// bit 0 on shift (new bit enters at the MSB), and clears on 'clear'.
// Ports:
//   clk           in   TAP clock
//   rst           in   synchronous active-high reset
//   clear         in   synchronous clear (TAP Test-Logic-Reset)
//   capture_en    in   load capture_data
//   shift_en      in   shift one position, tdi enters at MSB
//   capture_data  in   DR_W parallel load value
//   tdi           in   serial input
//   sr            out  current register contents (sr[0] is the serial out)
// ---------------------------------------------------------------------------
module roalogic_dbg_dr_shifter
  import roalogic_dbg_pkg::*;
#(
  parameter int unsigned DR_W = 42
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            capture_en,
  input  logic            shift_en,
  input  logic [DR_W-1:0] capture_data,
  input  logic            tdi,
  output logic [DR_W-1:0] sr
);

  logic [DR_W-1:0] sr_d;
  logic [DR_W-1:0] sr_q;

  // Next register value; clear has priority over capture and shift
  always_comb begin
    sr_d = sr_q;
    if (clear) begin
      sr_d = '0;
    end else if (capture_en) begin
      sr_d = capture_data;
    end else if (shift_en) begin
      sr_d = {tdi, sr_q[DR_W-1:1]};
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register storage
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr = sr_q;

endmodule

// File: rtl/roalogic_dbg_bridge.sv
// ---------------------------------------------------------------------------
// roalogic_dbg_bridge
// Debug DR stage behind the JTAG TAP. A frame {data, addr, cmd[1:0]} is
// shifted in LSB first; on UpdateDR the command is decoded and a single
// read/write is issued on a req/ack bus in the jtag_tck domain. Read data
// and status {rdata, zeros, bus_error, overrun, busy} come back on the next
// CaptureDR.
// Optional feature macro: DBG_BUS_TIMEOUT_EN -- abort a request that is not
// acknowledged within TIMEOUT_CYCLES cycles and flag a bus error.
// Ports:
//   jtag_tck, jtag_rst            clock, synchronous active-high reset
//   dbg_sel                       DEBUG instruction selected (gates strobes)
//   dbg_tdi / dbg_tdo             serial in / out (dbg_tdo = sr[0])
//   tap_TestLogicReset, tap_CaptureDR, tap_ShiftDR, tap_UpdateDR   TAP strobes
//   bus_req, bus_we, bus_addr, bus_wdata   registered request outputs
//   bus_ack, bus_rdata, bus_err            completion inputs
// ---------------------------------------------------------------------------
module roalogic_dbg_bridge
  import roalogic_dbg_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              jtag_tck,
  input  logic              jtag_rst,
  input  logic              dbg_sel,
  input  logic              dbg_tdi,
  output logic              dbg_tdo,
  input  logic              tap_TestLogicReset,
  input  logic              tap_CaptureDR,
  input  logic              tap_ShiftDR,
  input  logic              tap_UpdateDR,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);

  localparam int unsigned DR_W  = 2 + ADDR_W + DATA_W;
  localparam int unsigned PAD_W = ADDR_W + 2 - STAT_W;

  logic [DR_W-1:0]   sr;
  logic [DR_W-1:0]   capture_data;
  dbg_cmd_e          upd_cmd;
  logic [ADDR_W-1:0] upd_addr;
  logic [DATA_W-1:0] upd_data;
  logic              upd_valid;
  logic              upd_rw;
  logic              busy;
  logic              ack_done;
  logic              timeout_hit;

  dbg_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              overrun_q, overrun_d;
  logic              bus_error_q, bus_error_d;

  assign busy         = (state_q == ST_REQ);
  assign capture_data = {rdata_q, {PAD_W{1'b0}}, bus_error_q, overrun_q, busy};

  roalogic_dbg_dr_shifter #(
    .DR_W (DR_W)
  ) u_dr_shifter (
    .clk          (jtag_tck),
    .rst          (jtag_rst),
    .clear        (tap_TestLogicReset),
    .capture_en   (dbg_sel & tap_CaptureDR),
    .shift_en     (dbg_sel & tap_ShiftDR),
    .capture_data (capture_data),
    .tdi          (dbg_tdi),
    .sr           (sr)
  );

  assign dbg_tdo   = sr[0];
  assign upd_cmd   = dbg_cmd_e'(sr[1:0]);
  assign upd_addr  = sr[2 +: ADDR_W];
  assign upd_data  = sr[2 + ADDR_W +: DATA_W];
  assign upd_valid = dbg_sel & tap_UpdateDR;
  assign upd_rw    = upd_valid & ((upd_cmd == CMD_WRITE) | (upd_cmd == CMD_READ));
  // bus_ack only counts while a request is outstanding
  assign ack_done  = busy & bus_ack;

`ifdef DBG_BUS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Held at zero while idle so it starts from zero on REQ entry
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!busy) begin
      to_cnt_d = '0;
    end else if (!bus_ack) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Timeout counter register
  always_ff @(posedge jtag_tck) begin
    if (jtag_rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  // The current cycle is the last permitted one; an ack in it still wins
  assign timeout_hit = busy & ~bus_ack & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, bus outputs, read data and sticky flags
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    overrun_d   = overrun_q;
    bus_error_d = bus_error_q;

    case (state_q)
      ST_IDLE: begin
        if (upd_rw) begin
          state_d     = ST_REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = (upd_cmd == CMD_WRITE);
          bus_addr_d  = upd_addr;
          bus_wdata_d = upd_data;
        end else begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
        end
      end
      ST_REQ: begin
        // Address/data/we stay frozen for the whole request
        if (ack_done || timeout_hit) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
        end else begin
          state_d   = ST_REQ;
          bus_req_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase

    if (ack_done && !bus_we_q) begin
      rdata_d = bus_rdata;
    end else begin
      rdata_d = rdata_q;
    end

    // Sets beat a same-cycle STATUS clear; TAP reset clears unconditionally
    if (tap_TestLogicReset) begin
      overrun_d   = 1'b0;
      bus_error_d = 1'b0;
    end else begin
      if (upd_rw && busy) begin
        overrun_d = 1'b1;
      end else if (upd_valid && (upd_cmd == CMD_STATUS)) begin
        overrun_d = 1'b0;
      end else begin
        overrun_d = overrun_q;
      end
      if ((ack_done && bus_err) || timeout_hit) begin
        bus_error_d = 1'b1;
      end else if (upd_valid && (upd_cmd == CMD_STATUS)) begin
        bus_error_d = 1'b0;
      end else begin
        bus_error_d = bus_error_q;
      end
    end
  end

  // FSM state and all registered outputs
  always_ff @(posedge jtag_tck) begin
    if (jtag_rst) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      overrun_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      overrun_q   <= overrun_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_roalogic_dbg_bridge.sv
// ---------------------------------------------------------------------------
// Self-checking bench for roalogic_dbg_bridge (ADDR_W=8, DATA_W=32, DR_W=42).
// A transaction-level model of the bridge is advanced on every clock edge
// from the bench's own inputs and compared against the DUT on each falling
// edge; directed scenarios additionally check hand-computed literals.
// ---------------------------------------------------------------------------
module tb_roalogic_dbg_bridge;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int DR_W    = 42;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              jtag_rst = 1'b1;
  logic              dbg_sel = 1'b0;
  logic              dbg_tdi = 1'b0;
  logic              dbg_tdo;
  logic              tap_TestLogicReset = 1'b0;
  logic              tap_CaptureDR = 1'b0;
  logic              tap_ShiftDR = 1'b0;
  logic              tap_UpdateDR = 1'b0;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack = 1'b0;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic              bus_err = 1'b0;

  always #5 clk = ~clk;

  roalogic_dbg_bridge #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .jtag_tck           (clk),
    .jtag_rst           (jtag_rst),
    .dbg_sel            (dbg_sel),
    .dbg_tdi            (dbg_tdi),
    .dbg_tdo            (dbg_tdo),
    .tap_TestLogicReset (tap_TestLogicReset),
    .tap_CaptureDR      (tap_CaptureDR),
    .tap_ShiftDR        (tap_ShiftDR),
    .tap_UpdateDR       (tap_UpdateDR),
    .bus_req            (bus_req),
    .bus_we             (bus_we),
    .bus_addr           (bus_addr),
    .bus_wdata          (bus_wdata),
    .bus_ack            (bus_ack),
    .bus_rdata          (bus_rdata),
    .bus_err            (bus_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: one transaction in flight, its age in cycles,
  // the sticky flags and the 42-bit data register.
  // ------------------------------------------------------------------
  bit [41:0] m_sr;
  bit        m_req;
  bit        m_we;
  bit [7:0]  m_addr;
  bit [31:0] m_wdata;
  bit [31:0] m_rdata;
  bit        m_ovr;
  bit        m_berr;
  int        m_age;
  bit        model_valid = 1'b0;

  always @(posedge clk) begin : model
    bit [41:0] cap;
    bit [1:0]  cmd;
    bit        upd, rw, fin, tmo, set_ovr, set_berr, clr;
    if (jtag_rst) begin
      m_sr = '0; m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_rdata = '0; m_ovr = 0; m_berr = 0; m_age = 0;
      model_valid = 1'b1;
    end else begin
      cap      = {m_rdata, 7'd0, m_berr, m_ovr, m_req};
      cmd      = m_sr[1:0];
      upd      = dbg_sel && tap_UpdateDR;
      rw       = upd && (cmd == 2'd1 || cmd == 2'd2);
      fin      = m_req && bus_ack;
      tmo      = 1'b0;
`ifdef DBG_BUS_TIMEOUT_EN
      tmo      = m_req && !bus_ack && (m_age + 1 == TIMEOUT);
`endif
      set_ovr  = rw && m_req;
      set_berr = (fin && bus_err) || tmo;
      clr      = upd && cmd == 2'd3;
      if (fin && !m_we) m_rdata = bus_rdata;
      if (m_req) begin
        if (fin || tmo) m_req = 0;
        else m_age = m_age + 1;
      end else if (rw) begin
        m_req   = 1;
        m_we    = (cmd == 2'd1);
        m_addr  = m_sr[9:2];
        m_wdata = m_sr[41:10];
        m_age   = 0;
      end
      if (tap_TestLogicReset) m_sr = '0;
      else if (dbg_sel && tap_CaptureDR) m_sr = cap;
      else if (dbg_sel && tap_ShiftDR) m_sr = {dbg_tdi, m_sr[41:1]};
      if (tap_TestLogicReset) begin
        m_ovr = 0; m_berr = 0;
      end else begin
        if (set_ovr) m_ovr = 1; else if (clr) m_ovr = 0;
        if (set_berr) m_berr = 1; else if (clr) m_berr = 0;
      end
    end
  end

  // Continuous comparison against the model on the falling edge
  always @(negedge clk) begin
    if (model_valid) begin
      check("tdo", dbg_tdo, m_sr[0]);
      check("bus_req", bus_req, m_req);
      check("bus_we", bus_we, m_we);
      check("bus_addr", bus_addr, m_addr);
      check("bus_wdata", bus_wdata, m_wdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Capture, shift 42 bits (collecting dbg_tdo), optional UpdateDR
  task automatic dr_scan(input logic [41:0] din, output logic [41:0] dout, input bit do_update);
    dbg_sel = 1'b1;
    tap_CaptureDR = 1'b1;
    cyc();
    tap_CaptureDR = 1'b0;
    tap_ShiftDR = 1'b1;
    for (int i = 0; i < DR_W; i++) begin
      dout[i] = dbg_tdo;
      dbg_tdi = din[i];
      cyc();
    end
    tap_ShiftDR = 1'b0;
    dbg_tdi = 1'b0;
    if (do_update) begin
      tap_UpdateDR = 1'b1;
      cyc();
      tap_UpdateDR = 1'b0;
    end
  endtask

  logic [41:0] dout;
  logic [41:0] nop_frame;
  logic [41:0] status_frame;
  logic [2:0]  stat;
  int          hi_cnt;

  initial begin
    nop_frame    = '0;
    status_frame = {40'd0, 2'b11};

    // Reset
    cyc(); cyc();
    check("rst_req", bus_req, 1'b0);
    check("rst_we", bus_we, 1'b0);
    check("rst_addr", bus_addr, 8'h00);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_tdo", dbg_tdo, 1'b0);
    jtag_rst = 1'b0;
    cyc();

    // Write
    dr_scan({32'hDEADBEEF, 8'h10, 2'b01}, dout, 1'b1);
    check("wr_req", bus_req, 1'b1);
    check("wr_we", bus_we, 1'b1);
    check("wr_addr", bus_addr, 8'h10);
    check("wr_wdata", bus_wdata, 32'hDEADBEEF);
    cyc(); cyc();
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0;
    check("wr_req_drop", bus_req, 1'b0);

    // Read
    dr_scan({32'h0, 8'h20, 2'b10}, dout, 1'b1);
    check("rd_we", bus_we, 1'b0);
    check("rd_addr", bus_addr, 8'h20);
    bus_rdata = 32'h12345678;
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0;
    bus_rdata = '0;
    check("rd_req_drop", bus_req, 1'b0);
    dr_scan(nop_frame, dout, 1'b1);
    check("rd_capture", dout, {32'h12345678, 10'h000});

    // Overrun: repeat UpdateDR while the write is still pending
    dr_scan({32'h11111111, 8'h30, 2'b01}, dout, 1'b1);
    tap_UpdateDR = 1'b1;
    cyc();
    tap_UpdateDR = 1'b0;
    check("ovr_req", bus_req, 1'b1);
    check("ovr_addr", bus_addr, 8'h30);
    check("ovr_wdata", bus_wdata, 32'h11111111);
    dr_scan(nop_frame, dout, 1'b0);
    stat = dout[2:0];
    check("ovr_status", stat, 3'b011);
    dr_scan(status_frame, dout, 1'b1);
    dr_scan(nop_frame, dout, 1'b0);
    stat = dout[2:0];
`ifdef DBG_BUS_TIMEOUT_EN
    check("ovr_after_status", stat, 3'b000);
`else
    check("ovr_after_status", stat, 3'b001);
`endif
    check("ovr_rdata_kept", dout[41:10], 32'h12345678);
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0;
    check("ovr_req_drop", bus_req, 1'b0);

    // Read completing with an error
    dr_scan({32'h0, 8'h50, 2'b10}, dout, 1'b1);
    bus_rdata = 32'hCAFEF00D;
    bus_err = 1'b1;
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0;
    bus_err = 1'b0;
    bus_rdata = '0;
    dr_scan(status_frame, dout, 1'b1);
    stat = dout[2:0];
    check("err_status", stat, 3'b100);
    check("err_rdata", dout[41:10], 32'hCAFEF00D);
    dr_scan(nop_frame, dout, 1'b0);
    stat = dout[2:0];
    check("err_cleared", stat, 3'b000);

    // dbg_sel=0: strobes must not touch sr or start a transfer
    dr_scan({32'h0, 8'h60, 2'b01}, dout, 1'b0);
    check("sel_pre_tdo", dbg_tdo, 1'b1);
    dbg_sel = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tap_CaptureDR = (i % 3 == 0);
      tap_ShiftDR   = (i % 3 == 1);
      tap_UpdateDR  = (i % 3 == 2);
      dbg_tdi       = (i % 2 == 0);
      cyc();
      check("sel0_tdo", dbg_tdo, 1'b1);
      check("sel0_req", bus_req, 1'b0);
    end
    tap_CaptureDR = 1'b0;
    tap_ShiftDR = 1'b0;
    tap_UpdateDR = 1'b0;
    dbg_tdi = 1'b0;
    tap_TestLogicReset = 1'b1;
    cyc();
    tap_TestLogicReset = 1'b0;
    check("tlr_tdo", dbg_tdo, 1'b0);
    dbg_sel = 1'b1;

    // Unacknowledged request
    dr_scan({32'hA5A5A5A5, 8'h70, 2'b01}, dout, 1'b1);
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_req) hi_cnt++;
      cyc();
    end
`ifdef DBG_BUS_TIMEOUT_EN
    check("to_req_cycles", hi_cnt, 16);
    dr_scan(nop_frame, dout, 1'b0);
    stat = dout[2:0];
    check("to_status", stat, 3'b100);
    check("to_rdata_kept", dout[41:10], 32'hCAFEF00D);
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0;
    check("to_late_ack", bus_req, 1'b0);
`else
    check("noto_req_cycles", hi_cnt, 40);
    check("noto_req_high", bus_req, 1'b1);
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0;
    check("noto_req_drop", bus_req, 1'b0);
`endif

    // Reset during a transfer
    dr_scan({32'h55AA55AA, 8'hFF, 2'b01}, dout, 1'b1);
    check("mr_req", bus_req, 1'b1);
    jtag_rst = 1'b1;
    cyc();
    jtag_rst = 1'b0;
    check("mr_req0", bus_req, 1'b0);
    check("mr_we0", bus_we, 1'b0);
    check("mr_addr0", bus_addr, 8'h00);
    check("mr_wdata0", bus_wdata, 32'h0);
    check("mr_tdo0", dbg_tdo, 1'b0);
    bus_ack = 1'b1;
    cyc();
    bus_ack = 1'b0;
    check("mr_late_ack", bus_req, 1'b0);
    dr_scan(nop_frame, dout, 1'b0);
    check("mr_capture", dout, 42'd0);

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
